// File: rtl/ysyx_220066_memrd_pipe_if.sv
// Load-port bundle: request channel, in-order response channel, and the word-read
// port that the memory model serves combinationally in the accept cycle.
interface ysyx_220066_memrd_pipe_if #(
    parameter int ADDR_W = 64
);
    // Handshake: a beat transfers on a rising clk edge where valid && ready are both high.
    // The sender holds valid and its payload until that edge; ready never waits on valid.
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [63:0]       rsp_data;
    logic              rsp_error;
    logic              busy;
    logic              mem_rd_en;
    logic [63:0]       mem_rd_addr;
    logic [63:0]       mem_rdata;
    logic              mem_fault;

    modport master (
        output req_valid, req_addr, req_size, req_signed, rsp_ready, mem_rdata, mem_fault,
        input  req_ready, rsp_valid, rsp_data, rsp_error, busy, mem_rd_en, mem_rd_addr
    );

    modport slave (
        input  req_valid, req_addr, req_size, req_signed, rsp_ready, mem_rdata, mem_fault,
        output req_ready, rsp_valid, rsp_data, rsp_error, busy, mem_rd_en, mem_rd_addr
    );
endinterface

// File: rtl/ysyx_220066_memrd_pipe.sv
// Pipelined memory read port: aligned 64-bit word read at accept, lane extract and
// extension, LATENCY-deep result pipe, then an in-order response FIFO bounded by credits.
module ysyx_220066_memrd_pipe #(
    parameter int ADDR_W  = 64,
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    ysyx_220066_memrd_pipe_if.slave          bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [63:0]   addr64;
    logic [2:0]    align_mask;
    logic          misaligned;
    logic          accept;
    logic          pop;
    logic [PW:0]   credits;
    logic [63:0]   lane;
    logic [63:0]   ext_data;
    logic [63:0]   res_data;
    logic          res_err;

    logic [LATENCY-1:0] pipe_valid;
    logic [LATENCY-1:0] pipe_err;
    logic [63:0]        pipe_data [LATENCY];

    logic [63:0]   fifo_data [DEPTH];
    logic [DEPTH-1:0] fifo_err;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   fifo_count;
    logic          fifo_wr;

    assign addr64 = 64'(bus.req_addr);

    always_comb begin
        align_mask = 3'b000;
        case (bus.req_size)
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    end

    assign misaligned    = |(addr64[2:0] & align_mask);
    assign bus.req_ready = !rst && (credits < DEPTH_C);
    assign accept        = bus.req_valid && bus.req_ready;
    // Misaligned requests never touch memory; they still occupy a slot and return an error.
    assign bus.mem_rd_en   = accept && !misaligned;
    assign bus.mem_rd_addr = {addr64[63:3], 3'b000};

    always_comb begin
        lane     = bus.mem_rdata >> {addr64[2:0], 3'b000};
        ext_data = '0;
        case (bus.req_size)
            2'd0: ext_data = bus.req_signed ? {{56{lane[7]}}, lane[7:0]}   : {56'd0, lane[7:0]};
            2'd1: ext_data = bus.req_signed ? {{48{lane[15]}}, lane[15:0]} : {48'd0, lane[15:0]};
            2'd2: ext_data = bus.req_signed ? {{32{lane[31]}}, lane[31:0]} : {32'd0, lane[31:0]};
            default: ext_data = lane;
        endcase
        res_err  = misaligned || bus.mem_fault;
        res_data = res_err ? 64'd0 : ext_data;
    end

    // Credits count everything between accept and pop, so the FIFO can always absorb the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   credits <= credits + (PW+1)'(1);
                2'b01:   credits <= credits - (PW+1)'(1);
                default: credits <= credits;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_data[0] <= res_data;
        pipe_err[0]  <= res_err;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
            pipe_err[i]  <= pipe_err[i-1];
        end
    end

    assign fifo_wr = pipe_valid[LATENCY-1];
    assign pop     = bus.rsp_valid && bus.rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({fifo_wr, pop})
                2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_data[wr_ptr] <= pipe_data[LATENCY-1];
            fifo_err[wr_ptr]  <= pipe_err[LATENCY-1];
        end
    end

    assign bus.rsp_valid = (fifo_count != '0);
    assign bus.rsp_data  = bus.rsp_valid ? fifo_data[rd_ptr] : 64'd0;
    assign bus.rsp_error = bus.rsp_valid ? fifo_err[rd_ptr]  : 1'b0;
    assign bus.busy      = (credits != '0);
endmodule
